// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-bank RAM agents: select-field geometry of
// bank_select and a constant-friendly clog2.
package meduram_pkg;

    // Bank index occupies the low bits of bank_select; the collision flag, when
    // present, sits directly above it.
    localparam int SEL_IDX_LSB = 0;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

    function automatic int sel_idx_width(input int nb_wragent);
        return (nb_wragent == 1) ? 1 : clog2(nb_wragent);
    endfunction

    function automatic int select_width(input int nb_wragent, input int write_collision);
        return sel_idx_width(nb_wragent) + write_collision;
    endfunction

    function automatic int sel_flag_bit(input int nb_wragent, input int write_collision);
        return select_width(nb_wragent, write_collision) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous active-high reset.
// The read word is forced to zero while the FIFO is empty.
module sync_fifo
    import meduram_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PTR_WIDTH = clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                      (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, and a resettable array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
    end

    assert property (@(posedge clk) disable iff (srst) !(push && full))
        else $error("sync_fifo: push into a full FIFO");

endmodule

// File: rtl/read_agent_port.sv
// Read-side front end for one read agent: broadcasts reads to all banks, carries
// the accounter's bank_select through the RAM latency and returns data in order.
module read_agent_port
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int NB_WRAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    parameter int SELECT_WIDTH    = select_width(NB_WRAGENT, WRITE_COLLISION),
    parameter int RAM_LATENCY     = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                           aclk,
    input  logic                           srst,
    input  logic                           rdvalid,
    output logic                           rdready,
    input  logic [ADDR_WIDTH-1:0]          rdaddr,
    output logic                           bank_rden,
    output logic [ADDR_WIDTH-1:0]          bank_rdaddr,
    input  logic [SELECT_WIDTH-1:0]        bank_select,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
    output logic                           outvalid,
    input  logic                           outready,
    output logic [DATA_WIDTH-1:0]          outdata,
    output logic                           outcollision
);

    localparam int IDX_WIDTH   = sel_idx_width(NB_WRAGENT);
    localparam int FLAG_BIT    = SELECT_WIDTH - 1;
    localparam int CNT_WIDTH   = clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_WIDTH = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FIFO_DEPTH);

    logic                    accept;
    logic                    pop;
    logic [CNT_WIDTH-1:0]    credit_q, credit_d;
    logic [SELECT_WIDTH-1:0] sel_q [RAM_LATENCY];
    logic [SELECT_WIDTH-1:0] sel_d [RAM_LATENCY];
    logic [RAM_LATENCY-1:0]  sel_vld_q, sel_vld_d;
    logic [SELECT_WIDTH-1:0] last_sel;
    logic [IDX_WIDTH-1:0]    last_idx;
    logic                    sel_flag;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_WIDTH-1:0]  fifo_rdata;

    // Credits cover in-flight reads plus FIFO entries, so the FIFO cannot overflow.
    assign rdready     = !srst && (credit_q < CNT_MAX);
    assign accept      = rdvalid && rdready;
    assign bank_rden   = accept;
    assign bank_rdaddr = rdaddr;

    assign outvalid     = !fifo_empty;
    assign pop          = outvalid && outready;
    assign outdata      = fifo_rdata[DATA_WIDTH-1:0];
    assign outcollision = fifo_rdata[DATA_WIDTH];

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        credit_d = credit_q;
        if (accept && !pop)      credit_d = credit_q + CNT_ONE;
        else if (pop && !accept) credit_d = credit_q - CNT_ONE;
    end

    always_comb begin
        sel_d[0]     = bank_select;
        sel_vld_d[0] = accept;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            sel_d[i]     = sel_q[i-1];
            sel_vld_d[i] = sel_vld_q[i-1];
        end
    end

    // The last select stage lines up with the bank data for the same request.
    always_comb begin
        last_sel = sel_q[RAM_LATENCY-1];
        last_idx = last_sel[SEL_IDX_LSB +: IDX_WIDTH];
        if (NB_WRAGENT == 1) last_idx = '0;
        sel_flag = (WRITE_COLLISION != 0) ? last_sel[FLAG_BIT] : 1'b0;
        sel_data = '0;
        if (int'(last_idx) >= NB_WRAGENT) begin
            sel_flag = 1'b1;
        end else begin
            for (int b = 0; b < NB_WRAGENT; b++) begin
                if (int'(last_idx) == b) sel_data = bank_rddata[DATA_WIDTH*b +: DATA_WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (srst) begin
            credit_q  <= '0;
            sel_vld_q <= '0;
        end else begin
            credit_q  <= credit_d;
            sel_vld_q <= sel_vld_d;
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < RAM_LATENCY; i++) sel_q[i] <= sel_d[i];
    end

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (aclk),
        .srst      (srst),
        .push      (sel_vld_q[RAM_LATENCY-1]),
        .push_data ({sel_flag, sel_data}),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/read_agent_port.md
Name: read_agent_port

Overview:
- Read-side front end for one read agent of the multi-bank RAM. It is the consumer of the accounter's bank_select and the reader counterpart to the write agents.
- Accepts read requests on a valid/ready handshake, issues the read to every bank and carries the bank selection through the RAM latency.
- Selects the data of the bank last written for that row, then returns data plus collision flag through a small output FIFO with backpressure.
- One instance per read agent. Sits between the agent and the bank array/accounter.

Parameters:
- ADDR_WIDTH, 8, read address width.
- DATA_WIDTH, 32, data width per bank.
- NB_WRAGENT, 2, number of banks (write agents), 1..4.
- WRITE_COLLISION, 1, 1 = bank_select MSB carries a collision flag.
- SELECT_WIDTH, (NB_WRAGENT==1 ? 1 : clog2(NB_WRAGENT)) + WRITE_COLLISION, bank_select width.
- RAM_LATENCY, 1, bank read latency in cycles, 1..4.
- FIFO_DEPTH, 4, output FIFO depth, power of 2, >= RAM_LATENCY+1.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- rdvalid  in  1  request valid.
- rdready  out  1  request ready.
- rdaddr  in  ADDR_WIDTH  request address.
- bank_rden  out  1  read enable broadcast to all banks.
- bank_rdaddr  out  ADDR_WIDTH  address broadcast to all banks and to the accounter.
- bank_select  in  SELECT_WIDTH  from the accounter, combinational on bank_rdaddr.
- bank_rddata  in  NB_WRAGENT*DATA_WIDTH  bank data, bank i at [DATA_WIDTH*i +: DATA_WIDTH].
- outvalid  out  1  response valid.
- outready  in  1  response ready.
- outdata  out  DATA_WIDTH  response data.
- outcollision  out  1  response flag: write collision or illegal bank index.

Behaviour:
- Single clock aclk. Reset srst is synchronous, active-high. All state clears on the aclk edge while srst=1.
- Reset values: rdready=0 while srst=1, then 1 on the first cycle after. bank_rden=0, outvalid=0, outdata=0, outcollision=0. FIFO empty, credit count 0, pipeline valids 0.
- Accept: a request is taken when rdvalid && rdready.
- In the accept cycle, bank_rden=1 and bank_rdaddr=rdaddr combinationally. When no request is taken, bank_rdaddr holds rdaddr and bank_rden=0.
- Select pipeline: on accept, bank_select is captured into a RAM_LATENCY-deep shift register with a valid bit per stage.
- Stage RAM_LATENCY lines up with bank_rddata for that request.
- Mux: the bank index is the low SELECT_WIDTH-WRITE_COLLISION bits of the captured select; with NB_WRAGENT=1 the index is 0.
- Flag = the select MSB when WRITE_COLLISION=1, else 0.
- An index >= NB_WRAGENT forces data=0 and flag=1.
- At the last stage, when its valid bit is set, {flag, data} is pushed into the FIFO.
- Latency: accept in cycle t gives outvalid=1 in cycle t+RAM_LATENCY+1 when the FIFO was empty. Full throughput is one request per cycle while outready=1.
- FIFO: first-word-fall-through. outvalid = !empty. Pop on outvalid && outready. outdata/outcollision hold stable while outvalid && !outready.
- Credit count = in-flight requests + FIFO entries, range 0..FIFO_DEPTH.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - rdready = !srst && count < FIFO_DEPTH.
  - This guarantees the FIFO never overflows; a push into a full FIFO is a design error, flagged by an assertion.
- Order: responses return strictly in request order.
- Reset mid-operation: in-flight requests and FIFO contents are discarded. No response is emitted for them.

Decomposition:
- Shared package meduram_pkg:
  - select-width function (same formula as the accounter).
  - clog2 helper.
  - localparams for the index-field and flag-bit positions within bank_select.
- Sub-module sync_fifo (DATA_WIDTH+1 wide, FIFO_DEPTH deep, FWFT, srst). It is reusable by other read agents.
- Select pipeline, mux and credit counter stay in read_agent_port.

Test Plan:
- Single read, RAM_LATENCY=1: bank_select=2'b01, bank1 data=0xDEADBEEF at addr 0x10 -> outvalid 2 cycles after accept, outdata=0xDEADBEEF, outcollision=0.
- Collision: bank_select=2'b11 -> outdata = bank1 data, outcollision=1.
- Backpressure, FIFO_DEPTH=4: outready=0, rdvalid held high -> exactly 4 accepts, then rdready=0. Raise outready -> responses drain in order at one per cycle, and rdready returns the cycle after the first pop.
- Back-to-back stream, RAM_LATENCY=3, addr 0..15 with alternating banks, outready=1 -> 16 in-order responses, one per cycle, first one 4 cycles after the first accept.
- NB_WRAGENT=3, bank_select index 2'b11 -> outdata=0, outcollision=1.
- srst asserted with 2 in flight and 2 in the FIFO -> next cycle outvalid=0, rdready=0 during reset and 1 after, no stale response ever appears.
